// File: rtl/truth_table_checker_pkg.sv
// Shared types and limits for the truth-table equivalence checker.
package truth_table_checker_pkg;

  localparam int N_MAX = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tt_state_e;

endpackage

// File: rtl/truth_table_checker.sv
// Sweeps all 2^N input vectors through two external combinational
// implementations and records both truth tables plus mismatch statistics.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; results of an aborted sweep are held
// RUN     | one minterm sampled per cycle, x_out counting up
// DONE    | sweep complete, done high, results valid until start/abort
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N-1:0]      x_out,
  input  logic              f_a,
  input  logic              f_b,
  output logic              busy,
  output logic              done,
  output logic              equal,
  output logic [N:0]        mismatch_cnt,
  output logic [N-1:0]      first_bad,
  output logic [(1<<N)-1:0] tt_a,
  output logic [(1<<N)-1:0] tt_b
);

  generate
    if (N < 1 || N > N_MAX) begin : g_bad_n
      $error("truth_table_checker: parameter N out of range 1..N_MAX");
    end
  endgenerate

  localparam int unsigned DEPTH   = 1 << N;
  localparam logic [N:0]  CNT_MAX = (N+1)'(DEPTH);
  localparam logic [N-1:0] X_LAST = '1;

  tt_state_e      state_q;
  logic [N-1:0]   first_bad_q;
  logic           mismatch;

  assign mismatch  = f_a ^ f_b;
  assign busy      = (state_q == ST_RUN);
  assign equal     = (mismatch_cnt == '0);
  assign first_bad = equal ? '0 : first_bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_out        <= '0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
      first_bad_q  <= '0;
      tt_a         <= '0;
      tt_b         <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // abort outranks start; results stay readable after an abort
          if (abort) begin
            done    <= 1'b0;
            state_q <= ST_IDLE;
          end else if (start) begin
            x_out        <= '0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            first_bad_q  <= '0;
            tt_a         <= '0;
            tt_b         <= '0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            done    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tt_a[x_out] <= f_a;
            tt_b[x_out] <= f_b;
            if (mismatch) begin
              if (mismatch_cnt == '0) first_bad_q <= x_out;
              if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
            end
            if (x_out == X_LAST) begin
              x_out   <= '0;
              done    <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              x_out <= x_out + 1'b1;
            end
          end
        end
        default: begin
          done    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter N, default 3: number of function inputs, legal range 1..6.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a 1-cycle pulse requests an exhaustive sweep.
REQ-005 SHALL have port abort, input, 1 bit: cancels a running sweep.
REQ-006 SHALL have port x_out, output, N bits: registered input vector driven to both external combinational implementations; bit N-1 is the MSB (X).
REQ-007 SHALL have port f_a, input, 1 bit: output of the full (canonical) implementation for the current x_out.
REQ-008 SHALL have port f_b, input, 1 bit: output of the simplified implementation for the current x_out.
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is running.
REQ-010 SHALL have port done, output, 1 bit: level; high after a completed sweep until the next start or abort.
REQ-011 SHALL have port equal, output, 1 bit: 1 when mismatch_cnt==0; valid while done is high.
REQ-012 SHALL have port mismatch_cnt, output, N+1 bits: number of differing minterms.
REQ-013 SHALL have port first_bad, output, N bits: lowest x_out index at which f_a!=f_b.
REQ-014 SHALL have port tt_a, output, 2^N bits: captured truth table of f_a, where bit i = f_a at x_out=i.
REQ-015 SHALL have port tt_b, output, 2^N bits: captured truth table of f_b, same bit layout as tt_a.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, encoded as a package enum.
REQ-017 SHALL, on start in IDLE or DONE, clear x_out, mismatch_cnt, first_bad, tt_a, tt_b and done, and enter RUN.
REQ-018 SHALL, every RUN cycle, sample f_a/f_b for the current x_out into tt_a[x_out]/tt_b[x_out] and increment mismatch_cnt when f_a!=f_b.
REQ-019 SHALL load first_bad with x_out only on the first mismatch of a sweep.
REQ-020 SHALL increment x_out by 1 each RUN cycle; sampling at x_out==2^N-1 SHALL transition to DONE with x_out wrapped to 0.
REQ-021 SHALL keep busy high for exactly 2^N cycles: the start edge k makes busy=1 from k+1, and done=1 from k+1+2^N.
REQ-022 SHALL ignore start while in RUN.
REQ-023 SHALL, on abort in RUN, go to IDLE with done=0, keeping partial results; abort has priority over start in the same cycle; abort in IDLE or DONE SHALL clear done only.
REQ-024 SHALL never wrap mismatch_cnt; N+1 bits holds a maximum of 2^N.
REQ-025 SHALL drive first_bad=0 when equal=1.

Reset
REQ-026 SHALL, on rst_n low, immediately set state=IDLE and x_out, busy, done, mismatch_cnt, first_bad, tt_a and tt_b to 0, and equal to 1.
REQ-027 SHALL treat reset during RUN as aborting the sweep, with no done pulse after release.
REQ-028 SHALL require a fresh start after rst_n deasserts; no sweep begins automatically.

Structure
REQ-029 SHALL place the state enum and constant N_MAX=6 in a shared package; N is checked against N_MAX at elaboration.
REQ-030 SHALL be a single module with no sub-module; the x_out counter and compare logic stay inline.

Verification
REQ-031 SHALL cover: N=3, f_a=(X|~Y|Z)&(~X|Y|Z), f_b=Z|(X xnor Y), start -> after 8 busy cycles done=1, equal=1, mismatch_cnt=0, tt_a=tt_b=8'hEB.
REQ-032 SHALL cover: N=3, same f_a, f_b=Z -> mismatch_cnt=2, first_bad=3'b000, tt_b=8'hAA, equal=0.
REQ-033 SHALL cover: abort at the 4th RUN cycle -> next cycle busy=0, done=0; restart -> full 8-cycle sweep with correct results.
REQ-034 SHALL cover: start pulsed again mid-RUN -> ignored; done still rises exactly 8 cycles after the first start.
REQ-035 SHALL cover: rst_n low mid-RUN -> all outputs 0 and equal=1 immediately; no done after release.
REQ-036 SHALL cover: N=1, f_a=X, f_b=~X -> mismatch_cnt=2, first_bad=0, tt_a=2'b10, tt_b=2'b01.
